id_ex_control: RTL
==================

# id_ex_control

Decode-stage control unit with registered ID/EX control outputs. Decodes the 32-bit instruction in ID into the EX/MEM/WB control word and registers it at the clock edge. The registered `o_aluop`, `o_opcode` and `o_funct` feed the combinational ALU control decoder in EX. It inserts bubbles on hazard stall or flush, and runs the HALT drain state machine that stops fetch and signals pipeline completion.

## Interface
- `SIZEOP`, 6, opcode/funct width
- `DRAIN_CYCLES`, 3, cycles after HALT enters EX until the pipeline is empty (EX, MEM, WB); legal 1..15
- `i_clk` in 1: single clock, rising edge
- `i_reset` in 1: synchronous, active-low reset
- `i_enable` in 1: debug step enable; low = every register and the FSM hold
- `i_instr` in 32: instruction from IF/ID
- `i_valid` in 1: `i_instr` is a real instruction
- `i_stall` in 1: load-use stall from hazard unit
- `i_flush` in 1: taken branch/jump squash
- `o_aluop` out 2: 00 LW/SW, 01 BEQ/BNE, 10 R-type, 11 I-type/NOP/HALT
- `o_opcode` out SIZEOP: `instr[31:26]`
- `o_funct` out SIZEOP: `instr[5:0]`
- `o_regdst`, `o_alusrc`, `o_memread`, `o_memwrite`, `o_memtoreg`, `o_regwrite` out 1 each: standard datapath controls
- `o_branch`, `o_bne`, `o_jump`, `o_jr`, `o_link` out 1 each: control-flow controls
- `o_valid` out 1: EX holds a real instruction
- `o_halt` out 1: EX holds HALT
- `o_halt_fetch` out 1: IF must stop advancing the PC
- `o_halted` out 1: pipeline drained; sticky until reset

## Operation
- **Decode table** (all unlisted controls 0):
  - R-type (000000): aluop=10, regdst, regwrite.
  - funct 001000 (JR): jr=1, regwrite=0.
  - funct 001001 (JALR): jr, link, regwrite, regdst.
  - LW 100011: aluop=00, alusrc, memread, memtoreg, regwrite.
  - SW 101011: aluop=00, alusrc, memwrite.
  - BEQ 000100: aluop=01, branch.
  - BNE 000101: aluop=01, branch, bne.
  - J 000010: jump.
  - JAL 000011: jump, link, regwrite.
  - ADDI/ANDI/ORI/XORI/LUI/SLTI: aluop=11, alusrc, regwrite.
  - NOP 111000: aluop=11, no enables, `o_valid`=1.
  - HALT 111111: aluop=11, `o_halt`=1, no enables.
  - Any other opcode: bubble, with `o_valid`=1.
- **Bubble** = aluop 00, opcode 111000, funct 0, all enables 0, `o_halt` 0, `o_valid` 0.
- **Priority each enabled edge:** reset > DRAIN/HALTED > flush > stall > `i_valid`=0 > decode. Each of the first five loads a bubble.
- **FSM states:** RUN, DRAIN, HALTED.
- **RUN:**
  - Decoded HALT (valid, no flush/stall) loads the HALT word.
  - Same edge: state goes to DRAIN, counter = `DRAIN_CYCLES`, `o_halt_fetch` = 1.
- **DRAIN:**
  - Bubbles only; inputs ignored, including flush.
  - Counter decrements each enabled edge.
  - Edge with counter==1 goes to HALTED.
- **HALTED:**
  - Bubbles; `o_halt_fetch` = 1, `o_halted` = 1.
  - Exit only by reset.
- **`i_enable` low:** outputs, state and counter hold exactly, including mid-drain.
- **Reset (any state, incl. mid-drain):** every output goes to its bubble value, `o_halt_fetch`=0, `o_halted`=0, state=RUN, counter=0.

## Timing
- Latency 1 cycle: decode of `i_instr` sampled at edge N appears on outputs after edge N.
- No combinational path from inputs to outputs; all outputs are registered.
- Stall and flush take effect on the same edge they are sampled.
- A stalled instruction is re-presented by IF/ID and decoded on the first edge with `i_stall`=0.
- HALT accepted at edge N:
  - `o_halt`=1 and `o_halt_fetch`=1 after edge N.
  - `o_halt` returns to 0 after edge N+1.
  - `o_halted`=1 after edge N+`DRAIN_CYCLES` (enabled edges only).
- HALT with `i_flush`=1 on the same edge: flushed, not accepted; FSM stays RUN.
- HALT with `i_stall`=1: not accepted that edge; accepted when re-presented without stall.

## Test plan
- **Reset:** hold `i_reset`=0 for 2 edges with `i_instr`=LW -> all outputs bubble, `o_halted`=0. Release and present LW 0x8C220004 -> after next edge aluop=00, alusrc=memread=memtoreg=regwrite=1, `o_valid`=1.
- **Decode sweep:**
  - ADDU funct 100001 -> aluop=10, regdst=1.
  - ORI -> aluop=11, opcode=001101.
  - BNE -> aluop=01, branch=bne=1.
  - JALR -> jr=link=regwrite=1.
  - Opcode 010000 -> bubble with `o_valid`=1.
- **Stall then flush:**
  - SW with `i_stall`=1 -> bubble; next edge with stall low -> memwrite=1.
  - `i_flush` and `i_stall` together on BEQ -> bubble.
- **HALT drain (`DRAIN_CYCLES`=3):**
  - HALT at edge N -> `o_halt`=1 for one cycle; `o_halt_fetch`=1 from N onward; `o_halted`=1 after N+3.
  - Subsequent ADDI inputs -> bubbles.
- **Enable freeze:** drop `i_enable` for 5 cycles mid-drain -> outputs frozen; `o_halted` delayed by exactly 5 cycles.
- **Reset mid-drain / HALT with flush:**
  - `i_reset`=0 at drain cycle 2 -> RUN, `o_halt_fetch`=0.
  - HALT with `i_flush`=1 -> FSM stays RUN, `o_halt`=0.

Source files
------------

// File: rtl/id_ex_control.sv
// id_ex_control
// Decode-stage control unit. It decodes the ID instruction into the
// EX/MEM/WB control word and registers that word into the ID/EX stage. On a
// hazard stall or flush it inserts bubbles instead. It also runs the HALT
// drain state machine, which stops fetch and then reports that the pipeline
// has emptied.
//
// Ports
//   i_clk, i_reset   : clock (rising edge) and synchronous active-low reset
//   i_enable         : debug step enable; low freezes every register
//   i_instr, i_valid : instruction from IF/ID and its valid flag
//   i_stall, i_flush : load-use stall and taken-branch squash
//   o_aluop .. o_link: registered control word for EX/MEM/WB
//   o_valid, o_halt  : EX holds a real instruction / holds HALT
//   o_halt_fetch     : IF must stop advancing the PC
//   o_halted         : pipeline drained after HALT (sticky until reset)
//   o_state          : debug view of the drain FSM (0 RUN, 1 DRAIN, 2 HALTED)
//
// Handshake: there is no valid/ready backpressure. i_valid qualifies i_instr
// on every enabled edge. o_valid qualifies the registered word one cycle later.
module id_ex_control #(
  parameter int SIZEOP       = 6,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [31:0]       i_instr,
  input  logic              i_valid,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [1:0]        o_aluop,
  output logic [SIZEOP-1:0] o_opcode,
  output logic [SIZEOP-1:0] o_funct,
  output logic              o_regdst,
  output logic              o_alusrc,
  output logic              o_memread,
  output logic              o_memwrite,
  output logic              o_memtoreg,
  output logic              o_regwrite,
  output logic              o_branch,
  output logic              o_bne,
  output logic              o_jump,
  output logic              o_jr,
  output logic              o_link,
  output logic              o_valid,
  output logic              o_halt,
  output logic              o_halt_fetch,
  output logic              o_halted,
  output logic [1:0]        o_state
);

  typedef struct packed {
    logic [1:0]        aluop;
    logic [SIZEOP-1:0] opcode;
    logic [SIZEOP-1:0] funct;
    logic              regdst;
    logic              alusrc;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regwrite;
    logic              branch;
    logic              bne;
    logic              jump;
    logic              jr;
    logic              link;
    logic              valid;
    logic              halt;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_NOP   = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  // Bubble: a NOP-coded word with every enable low and o_valid low.
  localparam ctrl_t BUBBLE = '{
    aluop: 2'b00, opcode: SIZEOP'(OP_NOP), funct: '0,
    default: 1'b0
  };

  logic [5:0] op;
  logic [5:0] fn;
  ctrl_t      dec;
  ctrl_t      ctrl_q;
  state_t     state_q;
  logic [3:0] cnt_q;
  logic       halt_fetch_q;
  logic       halted_q;
  logic       unused_instr_bits;

  assign op = i_instr[31:26];
  assign fn = i_instr[5:0];
  // Register fields are decoded downstream; only opcode/funct matter here.
  assign unused_instr_bits = ^i_instr[25:6];

  always_comb begin
    dec        = BUBBLE;
    dec.valid  = 1'b1;
    dec.opcode = SIZEOP'(op);
    dec.funct  = SIZEOP'(fn);
    case (op)
      OP_RTYPE: begin
        dec.aluop = 2'b10;
        if (fn == FN_JR) begin
          dec.jr = 1'b1;
        end else if (fn == FN_JALR) begin
          dec.jr       = 1'b1;
          dec.link     = 1'b1;
          dec.regwrite = 1'b1;
          dec.regdst   = 1'b1;
        end else begin
          dec.regdst   = 1'b1;
          dec.regwrite = 1'b1;
        end
      end
      OP_LW: begin
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_SW: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec.aluop  = 2'b01;
        dec.branch = 1'b1;
      end
      OP_BNE: begin
        dec.aluop  = 2'b01;
        dec.branch = 1'b1;
        dec.bne    = 1'b1;
      end
      OP_J:   dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump     = 1'b1;
        dec.link     = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI: begin
        dec.aluop    = 2'b11;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_NOP:  dec.aluop = 2'b11;
      OP_HALT: begin
        dec.aluop = 2'b11;
        dec.halt  = 1'b1;
      end
      default: begin
        // An unknown opcode becomes a bubble, but it still occupies the slot.
        dec       = BUBBLE;
        dec.valid = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ctrl_q       <= BUBBLE;
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      halt_fetch_q <= 1'b0;
      halted_q     <= 1'b0;
    end else if (i_enable) begin
      case (state_q)
        ST_RUN: begin
          if (i_flush || i_stall || !i_valid) begin
            ctrl_q <= BUBBLE;
          end else begin
            ctrl_q <= dec;
            if (dec.halt) begin
              state_q      <= ST_DRAIN;
              cnt_q        <= 4'(DRAIN_CYCLES);
              halt_fetch_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The counter counts the EX, MEM and WB slots still occupied behind
          // HALT. The pipeline is empty on the edge the count reaches 1.
          ctrl_q <= BUBBLE;
          cnt_q  <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: ctrl_q <= BUBBLE;
        default: begin
          ctrl_q  <= BUBBLE;
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign o_aluop      = ctrl_q.aluop;
  assign o_opcode     = ctrl_q.opcode;
  assign o_funct      = ctrl_q.funct;
  assign o_regdst     = ctrl_q.regdst;
  assign o_alusrc     = ctrl_q.alusrc;
  assign o_memread    = ctrl_q.memread;
  assign o_memwrite   = ctrl_q.memwrite;
  assign o_memtoreg   = ctrl_q.memtoreg;
  assign o_regwrite   = ctrl_q.regwrite;
  assign o_branch     = ctrl_q.branch;
  assign o_bne        = ctrl_q.bne;
  assign o_jump       = ctrl_q.jump;
  assign o_jr         = ctrl_q.jr;
  assign o_link       = ctrl_q.link;
  assign o_valid      = ctrl_q.valid;
  assign o_halt       = ctrl_q.halt;
  assign o_halt_fetch = halt_fetch_q;
  assign o_halted     = halted_q;
  assign o_state      = state_q;

endmodule
